// File: rtl/axi4lite_pkg.sv
// Shared definitions for the AXI4-Lite command master.
//   state_e     : FSM state encoding (ST_IDLE .. ST_RD_RESP)
//   RESP_*      : AXI BRESP/RRESP codes
package axi4lite_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR_REQ  = 3'd1,
      ST_WR_RESP = 3'd2,
      ST_RD_REQ  = 3'd3,
      ST_RD_RESP = 3'd4
   } state_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi4lite_master_cmd_if.sv
// AXI4-Lite bus bundle (AW, W, B, AR, R channels).
//   master modport : drives valids on AW/W/AR, readies on B/R, address/data payload
//   slave modport  : mirror image
interface axi4lite_master_cmd_if #(
   parameter int unsigned ADDR_WIDTH = 32
);
   import axi4lite_pkg::*;

   logic                  awvalid;
   logic                  awready;
   logic [ADDR_WIDTH-1:0] awaddr;
   logic [2:0]            awprot;
   logic                  wvalid;
   logic                  wready;
   logic [31:0]           wdata;
   logic [3:0]            wstrb;
   logic                  bvalid;
   logic                  bready;
   logic [1:0]            bresp;
   logic                  arvalid;
   logic                  arready;
   logic [ADDR_WIDTH-1:0] araddr;
   logic [2:0]            arprot;
   logic                  rvalid;
   logic                  rready;
   logic [31:0]           rdata;
   logic [1:0]            rresp;

   modport master (
      output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
             arvalid, araddr, arprot, rready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

   modport slave (
      input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
             arvalid, araddr, arprot, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

endinterface

// File: rtl/axi4lite_master_cmd.sv
// AXI4-Lite initiator: turns a single-command register access into one AXI4-Lite
// write or read transaction, one outstanding at a time.
//   aclk, aresetn              : clock, async active-low reset
//   cmd_valid/cmd_ready        : command handshake; cmd_wr selects write (1) / read (0)
//   cmd_addr/cmd_wdata/wstrb   : command payload, captured on accept
//   rsp_valid                  : one-cycle response pulse with rsp_wr/rsp_rdata/rsp_resp
//   busy                       : transaction in flight
//   axi                        : AXI4-Lite master channels
module axi4lite_master_cmd
   import axi4lite_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter logic [2:0]  PROT       = 3'b000
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_wr,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [31:0]           cmd_wdata,
   input  logic [3:0]            cmd_wstrb,
   output logic                  rsp_valid,
   output logic                  rsp_wr,
   output logic [31:0]           rsp_rdata,
   output logic [1:0]            rsp_resp,
   output logic                  busy,
   axi4lite_master_cmd_if.master axi
);

   state_e                state_q, state_d;
   logic                  cmd_ready_q, cmd_ready_d;
   logic                  awvalid_q, awvalid_d;
   logic                  wvalid_q, wvalid_d;
   logic                  arvalid_q, arvalid_d;
   logic                  bready_q, bready_d;
   logic                  rready_q, rready_d;
   logic                  aw_done_q, aw_done_d;
   logic                  w_done_q, w_done_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [3:0]            wstrb_q, wstrb_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic                  rsp_wr_q, rsp_wr_d;
   logic [31:0]           rsp_rdata_q, rsp_rdata_d;
   logic [1:0]            rsp_resp_q, rsp_resp_d;

   logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

   assign aw_hs = awvalid_q & axi.awready;
   assign w_hs  = wvalid_q  & axi.wready;
   assign b_hs  = bready_q  & axi.bvalid;
   assign ar_hs = arvalid_q & axi.arready;
   assign r_hs  = rready_q  & axi.rvalid;

   always_comb begin
      state_d     = state_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      arvalid_d   = arvalid_q;
      bready_d    = bready_q;
      rready_d    = rready_q;
      aw_done_d   = aw_done_q;
      w_done_d    = w_done_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      rsp_valid_d = 1'b0;
      rsp_wr_d    = rsp_wr_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_resp_d  = rsp_resp_q;

      case (state_q)
         ST_IDLE: begin
            // Payload registers only ever load here, so they are stable under any valid.
            if (cmd_valid && cmd_ready_q) begin
               addr_d  = cmd_addr;
               wdata_d = cmd_wdata;
               wstrb_d = cmd_wstrb;
               if (cmd_wr) begin
                  state_d   = ST_WR_REQ;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  aw_done_d = 1'b0;
                  w_done_d  = 1'b0;
               end else begin
                  state_d   = ST_RD_REQ;
                  arvalid_d = 1'b1;
               end
            end
         end
         ST_WR_REQ: begin
            if (aw_hs) begin
               awvalid_d = 1'b0;
               aw_done_d = 1'b1;
            end
            if (w_hs) begin
               wvalid_d = 1'b0;
               w_done_d = 1'b1;
            end
            // Uses the _d flags so a same-cycle AW/W completion advances immediately.
            if (aw_done_d && w_done_d) begin
               state_d   = ST_WR_RESP;
               bready_d  = 1'b1;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
            end
         end
         ST_WR_RESP: begin
            if (b_hs) begin
               state_d     = ST_IDLE;
               bready_d    = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_wr_d    = 1'b1;
               rsp_rdata_d = 32'h0;
               rsp_resp_d  = axi.bresp;
            end
         end
         ST_RD_REQ: begin
            if (ar_hs) begin
               state_d   = ST_RD_RESP;
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
            end
         end
         ST_RD_RESP: begin
            if (r_hs) begin
               state_d     = ST_IDLE;
               rready_d    = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_wr_d    = 1'b0;
               rsp_rdata_d = axi.rdata;
               rsp_resp_d  = axi.rresp;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Registered ready: high in every cycle the FSM sits in IDLE, including the
      // response cycle, which allows back-to-back accepts.
      cmd_ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q     <= ST_IDLE;
         cmd_ready_q <= 1'b0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         bready_q    <= 1'b0;
         rready_q    <= 1'b0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= 32'h0;
         wstrb_q     <= 4'h0;
         rsp_valid_q <= 1'b0;
         rsp_wr_q    <= 1'b0;
         rsp_rdata_q <= 32'h0;
         rsp_resp_q  <= 2'b00;
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         arvalid_q   <= arvalid_d;
         bready_q    <= bready_d;
         rready_q    <= rready_d;
         aw_done_q   <= aw_done_d;
         w_done_q    <= w_done_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_wr_q    <= rsp_wr_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_resp_q  <= rsp_resp_d;
      end
   end

   assign cmd_ready   = cmd_ready_q;
   assign busy        = (state_q != ST_IDLE);
   assign rsp_valid   = rsp_valid_q;
   assign rsp_wr      = rsp_wr_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_resp    = rsp_resp_q;

   assign axi.awvalid = awvalid_q;
   assign axi.awaddr  = addr_q;
   assign axi.awprot  = PROT;
   assign axi.wvalid  = wvalid_q;
   assign axi.wdata   = wdata_q;
   assign axi.wstrb   = wstrb_q;
   assign axi.bready  = bready_q;
   assign axi.arvalid = arvalid_q;
   assign axi.araddr  = addr_q;
   assign axi.arprot  = PROT;
   assign axi.rready  = rready_q;

endmodule

// File: tb/tb_axi4lite_master_cmd.sv
// Self-checking bench for axi4lite_master_cmd: a task-driven AXI4-Lite slave with
// programmable per-channel wait states, expectations derived from the command stream.
module tb_axi4lite_master_cmd;
   import axi4lite_pkg::*;

   localparam int TMO = 60;

   logic        aclk    = 1'b0;
   logic        aresetn = 1'b1;
   logic        cmd_valid, cmd_ready, cmd_wr;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic        rsp_valid, rsp_wr, busy;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;

   axi4lite_master_cmd_if #(.ADDR_WIDTH(32)) axi ();

   axi4lite_master_cmd #(.ADDR_WIDTH(32), .PROT(3'b000)) dut (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_wr    (cmd_wr),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .cmd_wstrb (cmd_wstrb),
      .rsp_valid (rsp_valid),
      .rsp_wr    (rsp_wr),
      .rsp_rdata (rsp_rdata),
      .rsp_resp  (rsp_resp),
      .busy      (busy),
      .axi       (axi)
   );

   always #5 aclk = ~aclk;

   int checks = 0;
   int errors = 0;
   int exp_acc = 0, exp_wr = 0, exp_rd = 0;

   // Monitor: handshake counts and protocol-rule violations, sampled at the active edge.
   int cyc = 0;
   int acc_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0, rsp_cnt = 0;
   int viol_ready = 0, viol_stab = 0, viol_rsp = 0;
   logic        p_awvalid, p_wvalid, p_arvalid, p_rsp_valid;
   logic [31:0] p_awaddr, p_wdata, p_araddr;
   logic [3:0]  p_wstrb;

   always @(posedge aclk) begin
      cyc <= cyc + 1;
      if (cmd_valid && cmd_ready) acc_cnt <= acc_cnt + 1;
      if (axi.awvalid && axi.awready) aw_cnt <= aw_cnt + 1;
      if (axi.wvalid && axi.wready) w_cnt <= w_cnt + 1;
      if (axi.bvalid && axi.bready) b_cnt <= b_cnt + 1;
      if (axi.arvalid && axi.arready) ar_cnt <= ar_cnt + 1;
      if (axi.rvalid && axi.rready) r_cnt <= r_cnt + 1;
      if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
      if (cmd_ready && busy) viol_ready <= viol_ready + 1;
      if (rsp_valid && p_rsp_valid) viol_rsp <= viol_rsp + 1;
      if ((axi.awvalid && p_awvalid && axi.awaddr !== p_awaddr) ||
          (axi.wvalid && p_wvalid && (axi.wdata !== p_wdata || axi.wstrb !== p_wstrb)) ||
          (axi.arvalid && p_arvalid && axi.araddr !== p_araddr))
         viol_stab <= viol_stab + 1;
      p_awvalid   <= axi.awvalid;
      p_wvalid    <= axi.wvalid;
      p_arvalid   <= axi.arvalid;
      p_rsp_valid <= rsp_valid;
      p_awaddr    <= axi.awaddr;
      p_wdata     <= axi.wdata;
      p_wstrb     <= axi.wstrb;
      p_araddr    <= axi.araddr;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Values seen by the slave tasks.
   logic [31:0] s_awaddr, s_wdata, s_araddr;
   logic [3:0]  s_wstrb;
   int          s_aw_cyc, s_w_cyc, s_b_cyc;

   task automatic slave_aw(input int dly);
      int n = 0;
      while (axi.awvalid !== 1'b1 && n < TMO) begin @(negedge aclk); n++; end
      check("aw_wait_tmo", n < TMO, 1);
      repeat (dly) @(negedge aclk);
      s_awaddr     = axi.awaddr;
      check("awprot", axi.awprot, 3'b000);
      axi.awready  = 1'b1;
      @(negedge aclk);
      s_aw_cyc     = cyc;
      axi.awready  = 1'b0;
      check("awvalid_drop", axi.awvalid, 0);
   endtask

   task automatic slave_w(input int dly);
      int n = 0;
      while (axi.wvalid !== 1'b1 && n < TMO) begin @(negedge aclk); n++; end
      check("w_wait_tmo", n < TMO, 1);
      repeat (dly) @(negedge aclk);
      s_wdata    = axi.wdata;
      s_wstrb    = axi.wstrb;
      axi.wready = 1'b1;
      @(negedge aclk);
      s_w_cyc    = cyc;
      axi.wready = 1'b0;
      check("wvalid_drop", axi.wvalid, 0);
   endtask

   task automatic slave_b(input int dly, input logic [1:0] resp);
      int n = 0;
      while (axi.bready !== 1'b1 && n < TMO) begin @(negedge aclk); n++; end
      check("bready_tmo", n < TMO, 1);
      s_b_cyc = cyc;
      repeat (dly) @(negedge aclk);
      axi.bvalid = 1'b1;
      axi.bresp  = resp;
      @(negedge aclk);
      axi.bvalid = 1'b0;
      axi.bresp  = 2'b00;
      check("bready_drop", axi.bready, 0);
   endtask

   task automatic slave_ar(input int dly);
      int n = 0;
      while (axi.arvalid !== 1'b1 && n < TMO) begin @(negedge aclk); n++; end
      check("ar_wait_tmo", n < TMO, 1);
      repeat (dly) @(negedge aclk);
      s_araddr    = axi.araddr;
      axi.arready = 1'b1;
      @(negedge aclk);
      axi.arready = 1'b0;
      check("arvalid_drop", axi.arvalid, 0);
   endtask

   task automatic slave_r(input int dly, input logic [1:0] resp, input logic [31:0] data);
      int n = 0;
      int lost = 0;
      while (axi.rready !== 1'b1 && n < TMO) begin @(negedge aclk); n++; end
      check("rready_tmo", n < TMO, 1);
      for (int i = 0; i < dly; i++) begin
         @(negedge aclk);
         if (axi.rready !== 1'b1) lost++;
      end
      check("rready_held", lost, 0);
      axi.rvalid = 1'b1;
      axi.rresp  = resp;
      axi.rdata  = data;
      @(negedge aclk);
      axi.rvalid = 1'b0;
      axi.rresp  = 2'b00;
      axi.rdata  = 32'h0;
      check("rready_drop", axi.rready, 0);
   endtask

   // Called at a negedge; returns at the negedge right after the accepting edge.
   task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb);
      int n = 0;
      cmd_valid = 1'b1;
      cmd_wr    = wr;
      cmd_addr  = addr;
      cmd_wdata = data;
      cmd_wstrb = strb;
      while (cmd_ready !== 1'b1 && n < TMO) begin @(negedge aclk); n++; end
      check("cmd_accept_tmo", n < TMO, 1);
      @(negedge aclk);
      exp_acc++;
   endtask

   task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input int d_a, input int d_w, input int d_r,
                         input logic [1:0] resp, input logic [31:0] rdata, input bit hold,
                         input bit chk_lat);
      int n = 0;
      int acc_cyc, aw0, w0, last_hs;
      aw0 = aw_cnt;
      w0  = w_cnt;
      send_cmd(wr, addr, data, strb);
      acc_cyc = cyc;
      if (!hold) cmd_valid = 1'b0;
      check("busy_after_accept", busy, 1);
      check("cmd_ready_after_accept", cmd_ready, 0);
      if (wr) begin
         fork
            slave_aw(d_a);
            slave_w(d_w);
            slave_b(d_r, resp);
         join
         check("awaddr", s_awaddr, addr);
         check("wdata", s_wdata, data);
         check("wstrb", s_wstrb, strb);
         last_hs = (s_aw_cyc > s_w_cyc) ? s_aw_cyc : s_w_cyc;
         check("bready_after_aw_w", s_b_cyc >= last_hs, 1);
         exp_wr++;
      end else begin
         slave_ar(d_a);
         slave_r(d_r, resp, rdata);
         check("araddr", s_araddr, addr);
         exp_rd++;
      end
      while (rsp_valid !== 1'b1 && n < TMO) begin @(negedge aclk); n++; end
      check("rsp_tmo", n < TMO, 1);
      check("rsp_wr", rsp_wr, wr);
      check("rsp_rdata", rsp_rdata, wr ? 32'h0 : rdata);
      check("rsp_resp", rsp_resp, resp);
      check("cmd_ready_in_rsp", cmd_ready, 1);
      if (wr) begin
         check("one_aw_hs", aw_cnt - aw0, 1);
         check("one_w_hs", w_cnt - w0, 1);
      end
      if (chk_lat) check("latency_le4", (cyc - acc_cyc) <= 4, 1);
   endtask

   initial begin
      int stray;
      cmd_valid   = 1'b0;
      cmd_wr      = 1'b0;
      cmd_addr    = 32'h0;
      cmd_wdata   = 32'h0;
      cmd_wstrb   = 4'h0;
      axi.awready = 1'b0;
      axi.wready  = 1'b0;
      axi.bvalid  = 1'b0;
      axi.bresp   = 2'b00;
      axi.arready = 1'b0;
      axi.rvalid  = 1'b0;
      axi.rdata   = 32'h0;
      axi.rresp   = 2'b00;

      // Reset values.
      #2 aresetn = 1'b0;
      #1;
      check("rst_cmd_ready", cmd_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_awvalid", axi.awvalid, 0);
      check("rst_wvalid", axi.wvalid, 0);
      check("rst_arvalid", axi.arvalid, 0);
      check("rst_bready", axi.bready, 0);
      check("rst_rready", axi.rready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_awaddr", axi.awaddr, 0);
      check("rst_wdata", axi.wdata, 0);
      check("rst_rsp_rdata", rsp_rdata, 0);
      repeat (2) @(negedge aclk);
      aresetn = 1'b1;
      @(negedge aclk);
      check("cmd_ready_after_release", cmd_ready, 1);

      // Zero-wait write.
      do_txn(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, RESP_OKAY, 32'h0, 1'b0, 1'b1);
      // W before AW, AW before W, both together.
      do_txn(1'b1, 32'h14, 32'h0BAD_F00D, 4'h3, 3, 0, 0, RESP_OKAY, 32'h0, 1'b0, 1'b0);
      do_txn(1'b1, 32'h18, 32'hCAFE_0001, 4'hC, 0, 3, 1, RESP_OKAY, 32'h0, 1'b0, 1'b0);
      do_txn(1'b1, 32'h1C, 32'h5555_AAAA, 4'h5, 2, 2, 0, RESP_OKAY, 32'h0, 1'b0, 1'b0);
      // Read with slow R.
      do_txn(1'b0, 32'h24, 32'h0, 4'h0, 0, 0, 5, RESP_OKAY, 32'h1234_5678, 1'b0, 1'b0);
      // Error response passes through, next command normal.
      do_txn(1'b1, 32'h30, 32'h1, 4'h1, 0, 0, 0, RESP_SLVERR, 32'h0, 1'b0, 1'b0);
      do_txn(1'b0, 32'h34, 32'h0, 4'h0, 1, 0, 0, RESP_OKAY, 32'h0000_BEEF, 1'b0, 1'b0);

      // Stray B/R valids while idle are not acknowledged.
      stray = 0;
      axi.bvalid = 1'b1;
      axi.rvalid = 1'b1;
      repeat (3) begin
         @(negedge aclk);
         if (axi.bready !== 1'b0 || axi.rready !== 1'b0 || rsp_valid !== 1'b0) stray++;
      end
      axi.bvalid = 1'b0;
      axi.rvalid = 1'b0;
      check("stray_not_acked", stray, 0);

      // Alternating write/read with cmd_valid held high throughout.
      for (int i = 0; i < 6; i++) begin
         do_txn(i % 2 == 0, 32'h100 + 32'(i * 4), $urandom, 4'($urandom_range(1, 15)),
                $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                2'($urandom_range(0, 3)), $urandom, 1'b1, 1'b0);
      end
      cmd_valid = 1'b0;

      // Randomized traffic.
      for (int i = 0; i < 20; i++) begin
         do_txn(1'($urandom_range(0, 1)), $urandom & 32'h0000_FFFC, $urandom,
                4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), 2'($urandom_range(0, 3)), $urandom,
                1'($urandom_range(0, 1)), 1'b0);
      end
      cmd_valid = 1'b0;

      // Reset while a write is stuck in the request phase.
      @(negedge aclk);
      send_cmd(1'b1, 32'h40, 32'hFFFF_0000, 4'hF);
      cmd_valid = 1'b0;
      repeat (2) @(negedge aclk);
      check("mid_awvalid_before_rst", axi.awvalid, 1);
      #2 aresetn = 1'b0;
      #1;
      check("mid_rst_awvalid", axi.awvalid, 0);
      check("mid_rst_wvalid", axi.wvalid, 0);
      check("mid_rst_bready", axi.bready, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_cmd_ready", cmd_ready, 0);
      @(negedge aclk);
      aresetn = 1'b1;
      @(negedge aclk);
      check("cmd_ready_after_mid_rst", cmd_ready, 1);
      do_txn(1'b1, 32'h44, 32'h7777_8888, 4'hF, 0, 1, 0, RESP_OKAY, 32'h0, 1'b0, 1'b1);
      do_txn(1'b0, 32'h48, 32'h0, 4'h0, 0, 0, 0, RESP_DECERR, 32'hA5A5_5A5A, 1'b0, 1'b0);

      // Totals against the command stream.
      repeat (2) @(negedge aclk);
      check("total_accepts", acc_cnt, exp_acc);
      check("total_aw", aw_cnt, exp_wr);
      check("total_w", w_cnt, exp_wr);
      check("total_b", b_cnt, exp_wr);
      check("total_ar", ar_cnt, exp_rd);
      check("total_r", r_cnt, exp_rd);
      check("total_rsp", rsp_cnt, exp_wr + exp_rd);
      check("cmd_ready_only_idle", viol_ready, 0);
      check("rsp_single_cycle", viol_rsp, 0);
      check("payload_stable", viol_stab, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
